// File: rtl/matmul_apb_slave.sv
// APB completer for the matmul calculator: control/status registers, operand banks A/B, result bank.
// Optional MATMUL_APB_STRB_EN enables byte-lane write strobes; without it pstrb_i is ignored.
module matmul_apb_slave #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 16,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 0,
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_i,
   input  logic                    psel_i,
   input  logic                    penable_i,
   input  logic                    pwrite_i,
   input  logic [ADDR_WIDTH-1:0]   paddr_i,
   input  logic [DATA_WIDTH-1:0]   pwdata_i,
   input  logic [DATA_WIDTH/8-1:0] pstrb_i,
   output logic                    pready_o,
   output logic                    pslverr_o,
   output logic [DATA_WIDTH-1:0]   prdata_o,
   input  logic                    busy_i,
   input  logic                    done_i,
   input  logic                    res_we_i,
   input  logic [IW-1:0]           res_idx_i,
   input  logic [DATA_WIDTH-1:0]   res_data_i,
   output logic                    start_o,
   output logic [6:0]              cfg_o,
   input  logic [IW-1:0]           opa_rd_idx_i,
   input  logic [IW-1:0]           opb_rd_idx_i,
   output logic [DATA_WIDTH-1:0]   opa_rd_data_o,
   output logic [DATA_WIDTH-1:0]   opb_rd_data_o
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int RW = ADDR_WIDTH - 8;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t                r_state;
   logic [2:0]            r_wait_cnt;
   logic [6:0]            r_cfg;
   logic                  r_done;
   logic                  r_start;
   logic [DATA_WIDTH-1:0] r_opa [DEPTH];
   logic [DATA_WIDTH-1:0] r_opb [DEPTH];
   logic [DATA_WIDTH-1:0] r_res [DEPTH];

   logic [RW-1:0]         w_region;
   logic [5:0]            w_word;
   logic [IW-1:0]         w_idx;
   logic                  w_aligned, w_in_bank;
   logic                  w_is_ctrl, w_is_stat, w_is_opa, w_is_opb, w_is_res;
   logic                  w_err;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic [DATA_WIDTH-1:0] w_mask;
   logic                  w_strb0;
   logic                  w_wr_ok;

   assign w_region  = paddr_i[ADDR_WIDTH-1:8];
   assign w_word    = paddr_i[7:2];
   assign w_idx     = w_word[IW-1:0];
   assign w_aligned = (paddr_i[1:0] == 2'b00);
   assign w_in_bank = (int'(w_word) < DEPTH);
   assign w_is_ctrl = (w_region == RW'(0)) && (w_word == 6'd0);
   assign w_is_stat = (w_region == RW'(0)) && (w_word == 6'd1);
   assign w_is_opa  = (w_region == RW'(1)) && w_in_bank;
   assign w_is_opb  = (w_region == RW'(2)) && w_in_bank;
   assign w_is_res  = (w_region == RW'(3)) && w_in_bank;

`ifdef MATMUL_APB_STRB_EN
   always_comb begin
      w_mask = '0;
      for (int b = 0; b < NB; b++) w_mask[8*b +: 8] = {8{pstrb_i[b]}};
   end
   assign w_strb0 = pstrb_i[0];
`else
   logic w_unused_strb;
   assign w_unused_strb = ^pstrb_i;
   assign w_mask  = '1;
   assign w_strb0 = 1'b1;
`endif

   always_comb begin
      w_err   = 1'b0;
      w_rdata = '0;
      if (!w_aligned) begin
         w_err = 1'b1;
      end else if (w_is_ctrl) begin
         w_err        = pwrite_i && busy_i;
         w_rdata[7:1] = r_cfg;
      end else if (w_is_stat) begin
         // the DONE clear is the only write STATUS accepts
         w_err        = pwrite_i && !pwdata_i[1];
         w_rdata[1:0] = {r_done, busy_i};
      end else if (w_is_opa) begin
         w_err   = pwrite_i && busy_i;
         w_rdata = r_opa[w_idx];
      end else if (w_is_opb) begin
         w_err   = pwrite_i && busy_i;
         w_rdata = r_opb[w_idx];
      end else if (w_is_res) begin
         w_err   = pwrite_i;
         w_rdata = r_res[w_idx];
      end else begin
         w_err = 1'b1;
      end
   end

   assign pready_o  = psel_i && penable_i && (r_state != IDLE) && (r_wait_cnt == 3'd0);
   assign pslverr_o = pready_o && w_err;
   assign prdata_o  = (pready_o && !pwrite_i && !w_err) ? w_rdata : '0;
   assign w_wr_ok   = pready_o && pwrite_i && !w_err;

   assign start_o       = r_start;
   assign cfg_o         = r_cfg;
   assign opa_rd_data_o = (int'(opa_rd_idx_i) < DEPTH) ? r_opa[opa_rd_idx_i] : '0;
   assign opb_rd_data_o = (int'(opb_rd_idx_i) < DEPTH) ? r_opb[opb_rd_idx_i] : '0;

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_wait_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: if (psel_i && !penable_i) begin
               r_state    <= SETUP;
               r_wait_cnt <= 3'(WAIT_STATES);
            end
            SETUP, ACCESS: begin
               if (!psel_i) begin
                  r_state <= IDLE;
               end else if (penable_i) begin
                  if (r_wait_cnt != 3'd0) begin
                     r_wait_cnt <= r_wait_cnt - 3'd1;
                     r_state    <= ACCESS;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         r_cfg   <= '0;
         r_done  <= 1'b0;
         r_start <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_opa[i] <= '0;
            r_opb[i] <= '0;
            r_res[i] <= '0;
         end
      end else begin
         r_start <= w_wr_ok && w_is_ctrl && pwdata_i[0] && w_strb0;
         if (w_wr_ok && w_is_ctrl && w_strb0) r_cfg <= pwdata_i[7:1];
         // an engine done on the same edge as the clear keeps DONE set
         if (done_i) r_done <= 1'b1;
         else if (w_wr_ok && w_is_stat && pwdata_i[1] && w_strb0) r_done <= 1'b0;
         if (w_wr_ok && w_is_opa) r_opa[w_idx] <= (r_opa[w_idx] & ~w_mask) | (pwdata_i & w_mask);
         if (w_wr_ok && w_is_opb) r_opb[w_idx] <= (r_opb[w_idx] & ~w_mask) | (pwdata_i & w_mask);
         if (res_we_i && (int'(res_idx_i) < DEPTH)) r_res[res_idx_i] <= res_data_i;
      end
   end

endmodule

// File: tb/tb_matmul_apb_slave.sv
module tb_matmul_apb_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel0 = 1'b0, psel3 = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [15:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = 4'hF;
   logic        busy = 1'b0, done = 1'b0;
   logic        res_we0 = 1'b0;
   logic [5:0]  res_idx0 = '0, opa_idx0 = '0, opb_idx0 = '0;
   logic [31:0] res_data = '0;
   logic        res_we3 = 1'b0;
   logic [3:0]  res_idx3 = '0, opa_idx3 = '0, opb_idx3 = '0;

   logic        pready0, pslverr0, start0, pready3, pslverr3, start3;
   logic [31:0] prdata0, prdata3, opa_d0, opb_d0, opa_d3, opb_d3;
   logic [6:0]  cfg0, cfg3;

   int n_vec = 0, n_err = 0, start_cnt = 0;
   logic [31:0] rd, exp_strb;
   logic        er;
   int          cyc, sc;
   logic [15:0] rst_addrs [4];

   always #5 clk = ~clk;
   always @(negedge clk) if (start0) start_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   matmul_apb_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(64), .WAIT_STATES(0)) u0 (
      .clk(clk), .rst_i(rst), .psel_i(psel0), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .pready_o(pready0),
      .pslverr_o(pslverr0), .prdata_o(prdata0), .busy_i(busy), .done_i(done),
      .res_we_i(res_we0), .res_idx_i(res_idx0), .res_data_i(res_data), .start_o(start0),
      .cfg_o(cfg0), .opa_rd_idx_i(opa_idx0), .opb_rd_idx_i(opb_idx0),
      .opa_rd_data_o(opa_d0), .opb_rd_data_o(opb_d0));

   matmul_apb_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(16), .WAIT_STATES(3)) u3 (
      .clk(clk), .rst_i(rst), .psel_i(psel3), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .pready_o(pready3),
      .pslverr_o(pslverr3), .prdata_o(prdata3), .busy_i(busy), .done_i(done),
      .res_we_i(res_we3), .res_idx_i(res_idx3), .res_data_i(res_data), .start_o(start3),
      .cfg_o(cfg3), .opa_rd_idx_i(opa_idx3), .opb_rd_idx_i(opb_idx3),
      .opa_rd_data_o(opa_d3), .opb_rd_data_o(opb_d3));

   task automatic apb(input bit use3, input bit wr, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit dn, input bit rw,
                      output logic [31:0] o_rd, output logic o_er, output int o_cyc);
      @(posedge clk); #1;
      psel0 = !use3; psel3 = use3; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
      @(posedge clk); #1;
      penable = 1'b1;
      o_cyc = 2;
      @(negedge clk);
      while (!(use3 ? pready3 : pready0) && o_cyc < 40) begin
         @(negedge clk);
         o_cyc++;
      end
      chk("no_timeout", o_cyc < 40, 1'b1);
      o_rd = use3 ? prdata3 : prdata0;
      o_er = use3 ? pslverr3 : pslverr0;
      if (dn) done = 1'b1;
      if (rw) res_we0 = 1'b1;
      @(posedge clk); #1;
      psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; done = 1'b0; res_we0 = 1'b0;
   endtask

   initial begin
      rst_addrs = '{16'h000, 16'h004, 16'h100, 16'h3FC};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pready0", pready0, 1'b0);
      chk("rst_pslverr0", pslverr0, 1'b0);
      chk("rst_prdata0", prdata0, 32'h0);
      chk("rst_start0", start0, 1'b0);
      chk("rst_cfg0", cfg0, 7'h00);
      chk("rst_pready3", pready3, 1'b0);
      chk("rst_start3", start3, 1'b0);
      chk("rst_cfg3", cfg3, 7'h00);
      chk("rst_opb3", opb_d3, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         apb(0, 0, rst_addrs[i], 32'h0, 4'hF, 0, 0, rd, er, cyc);
         chk("reset_read_data", rd, 32'h0);
         chk("reset_read_err", er, 1'b0);
         chk("reset_read_cycles", cyc, 2);
      end

      apb(0, 1, 16'h104, 32'hDEADBEEF, 4'hF, 0, 0, rd, er, cyc);
      chk("opa1_wr_err", er, 1'b0);
      apb(0, 0, 16'h104, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("opa1_rd", rd, 32'hDEADBEEF);
      opa_idx0 = 6'd1; #1;
      chk("opa1_engine_port", opa_d0, 32'hDEADBEEF);
      apb(1, 1, 16'h104, 32'hDEADBEEF, 4'hF, 0, 0, rd, er, cyc);
      chk("ws3_wr_cycles", cyc, 5);
      chk("ws3_wr_err", er, 1'b0);
      apb(1, 0, 16'h104, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("ws3_rd_cycles", cyc, 5);
      chk("ws3_rd", rd, 32'hDEADBEEF);
      opa_idx3 = 4'd1; #1;
      chk("ws3_engine_port", opa_d3, 32'hDEADBEEF);
      apb(1, 0, 16'h140, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("idx_ge_depth_err", er, 1'b1);
      chk("idx_ge_depth_data", rd, 32'h0);
      apb(0, 0, 16'h140, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("idx16_depth64_err", er, 1'b0);

      busy = 1'b1;
      sc = start_cnt;
      apb(0, 1, 16'h000, 32'h1, 4'hF, 0, 0, rd, er, cyc);
      chk("start_busy_err", er, 1'b1);
      apb(0, 1, 16'h100, 32'h5, 4'hF, 0, 0, rd, er, cyc);
      chk("opa_busy_wr_err", er, 1'b1);
      apb(0, 0, 16'h104, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("rd_busy_err", er, 1'b0);
      chk("rd_busy_data", rd, 32'hDEADBEEF);
      apb(0, 0, 16'h004, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("status_busy", rd, 32'h1);
      chk("start_busy_nopulse", start_cnt, sc);
      busy = 1'b0;
      apb(0, 1, 16'h000, 32'hFE, 4'hF, 0, 0, rd, er, cyc);
      chk("cfg_wr_err", er, 1'b0);
      chk("cfg_o", cfg0, 7'h7F);
      apb(0, 0, 16'h000, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("ctrl_rd_cfg", rd, 32'hFE);
      apb(0, 1, 16'h000, 32'h1, 4'hF, 0, 0, rd, er, cyc);
      chk("start_wr_err", er, 1'b0);
      repeat (3) @(posedge clk);
      chk("start_single_pulse", start_cnt, sc + 1);
      apb(0, 0, 16'h000, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("ctrl_rd_after_start", rd, 32'h0);

      apb(0, 1, 16'h100, 32'h0BADF00D, 4'hF, 0, 0, rd, er, cyc);
      apb(0, 1, 16'h300, 32'h1111, 4'hF, 0, 0, rd, er, cyc);
      chk("wr_res_err", er, 1'b1);
      apb(0, 1, 16'h00C, 32'h2222, 4'hF, 0, 0, rd, er, cyc);
      chk("wr_unmapped_err", er, 1'b1);
      apb(0, 1, 16'h101, 32'h3333, 4'hF, 0, 0, rd, er, cyc);
      chk("wr_misaligned_err", er, 1'b1);
      apb(0, 1, 16'h004, 32'h1, 4'hF, 0, 0, rd, er, cyc);
      chk("wr_status_nonw1c_err", er, 1'b1);
      apb(0, 0, 16'h100, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("opa0_unchanged", rd, 32'h0BADF00D);
      apb(0, 0, 16'h300, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("res0_unchanged", rd, 32'h0);
      apb(0, 0, 16'h400, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("rd_unmapped_err", er, 1'b1);
      chk("rd_unmapped_data", rd, 32'h0);

      @(posedge clk); #1; done = 1'b1;
      @(posedge clk); #1; done = 1'b0;
      apb(0, 0, 16'h004, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("status_done", rd, 32'h2);
      apb(0, 1, 16'h004, 32'h2, 4'hF, 1, 0, rd, er, cyc);
      chk("w1c_err", er, 1'b0);
      apb(0, 0, 16'h004, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("status_set_wins", rd, 32'h2);
      apb(0, 1, 16'h004, 32'h2, 4'hF, 0, 0, rd, er, cyc);
      apb(0, 0, 16'h004, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("status_cleared", rd, 32'h0);

      apb(0, 1, 16'h208, 32'h11223344, 4'hF, 0, 0, rd, er, cyc);
      apb(0, 1, 16'h208, 32'hAABBCCDD, 4'b0101, 0, 0, rd, er, cyc);
      chk("strb_wr_err", er, 1'b0);
`ifdef MATMUL_APB_STRB_EN
      exp_strb = 32'h11BB33DD;
`else
      exp_strb = 32'hAABBCCDD;
`endif
      apb(0, 0, 16'h208, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("strb_merge", rd, exp_strb);
      opb_idx0 = 6'd2; #1;
      chk("strb_engine_port", opb_d0, exp_strb);

      @(posedge clk); #1; res_idx0 = 6'd5; res_data = 32'h55; res_we0 = 1'b1;
      @(posedge clk); #1; res_we0 = 1'b0; res_data = 32'h66;
      apb(0, 0, 16'h314, 32'h0, 4'hF, 0, 1, rd, er, cyc);
      chk("res_rd_old", rd, 32'h55);
      apb(0, 0, 16'h314, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("res_rd_new", rd, 32'h66);

      @(posedge clk); #1;
      psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h10C; pwdata = 32'h12345678; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1; #1;
      chk("midrst_pready_before", pready0, 1'b1);
      rst = 1'b1; #1;
      chk("midrst_pready_drop", pready0, 1'b0);
      @(posedge clk); #1;
      psel0 = 1'b0; penable = 1'b0; rst = 1'b0;
      apb(0, 0, 16'h10C, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("midrst_no_write", rd, 32'h0);
      apb(0, 0, 16'h104, 32'h0, 4'hF, 0, 0, rd, er, cyc);
      chk("midrst_bank_cleared", rd, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
